// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu_if
//  Description : Bundle of every handshake and bus signal of mem_stage_lsu.
//                The request/response handshake, the data memory port and
//                the UART byte stream are grouped together.
//                  slave  : the LSU view (mem_stage_lsu)
//                  master : the pipeline / memory / UART view
//  Parameters  : XLEN - datapath width (32 or 64)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_lsu_if #(
    parameter int XLEN = 32
);
    // request from execute stage
    logic              req_valid;
    logic              req_ready;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [2:0]        funct3;
    logic              mem_read;
    logic              mem_write;
    logic [4:0]        rd_in;
    // response to writeback stage
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic [4:0]        rd_out;
    logic              fault;
    // data memory port
    logic              dmem_en;
    logic [XLEN/8-1:0] dmem_we;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [XLEN-1:0]   dmem_rdata;
    // UART byte stream
    logic [7:0]        uart_tx_out;
    logic              uart_tx_valid;
    logic              uart_tx_ready;

    modport slave (
        input  req_valid, addr, wdata, funct3, mem_read, mem_write, rd_in,
        input  rsp_ready, dmem_rdata, uart_tx_ready,
        output req_ready, rsp_valid, rsp_data, rd_out, fault,
        output dmem_en, dmem_we, dmem_addr, dmem_wdata,
        output uart_tx_out, uart_tx_valid
    );

    modport master (
        output req_valid, addr, wdata, funct3, mem_read, mem_write, rd_in,
        output rsp_ready, dmem_rdata, uart_tx_ready,
        input  req_ready, rsp_valid, rsp_data, rd_out, fault,
        input  dmem_en, dmem_we, dmem_addr, dmem_wdata,
        input  uart_tx_out, uart_tx_valid
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu
//  Description : Memory-stage load/store unit. Accepts one request at a time,
//                performs a byte/half/word(/double) access on a fixed-latency
//                data memory, or a memory-mapped UART transmit / status
//                access, and returns a single response.
//  Ports       : clk, rst (synchronous, active high)
//                bus : mem_stage_lsu_if.slave - request, response, dmem, UART
//  Parameters  : XLEN (32/64), MEM_LATENCY (1..8), UART_TX_ADDR,
//                UART_STAT_ADDR, TX_DEPTH (power of two, 2..16)
//  Build option: LSU_MISALIGN_CHECK_EN - when defined, an access not naturally
//                aligned to its size faults; otherwise the low address bits
//                are forced to natural alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int          XLEN           = 32,
    parameter int          MEM_LATENCY    = 1,
    parameter logic [31:0] UART_TX_ADDR   = 32'h1000_0000,
    parameter logic [31:0] UART_STAT_ADDR = 32'h1000_0004,
    parameter int          TX_DEPTH       = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_stage_lsu_if.slave     bus
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PW   = $clog2(TX_DEPTH);
    localparam int LATW = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        WAIT   = 3'd2,
        UART   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------------
    // Request decode (valid while IDLE, consumed on acceptance)
    // ------------------------------------------------------------------------
    logic            is_store, is_load, is_mem;
    logic [1:0]      size;         // log2 of access size in bytes
    logic            uns;          // zero-extend load
    logic            f3_legal;
    logic [OFFW-1:0] off_raw, off_eff, size_mask;
    logic            access_fault;
    logic            is_uart_tx, is_uart_stat;
    logic [NB-1:0]   lane_base, lane_mask;
    logic [XLEN-1:0] wrep;

    // both mem_read and mem_write set behaves as a store
    assign is_store = bus.mem_write;
    assign is_load  = bus.mem_read & ~bus.mem_write;
    assign is_mem   = bus.mem_read | bus.mem_write;

    always_comb begin
        size     = 2'd0;
        uns      = 1'b0;
        f3_legal = 1'b1;
        case (bus.funct3)
            3'b000: size = 2'd0;
            3'b001: size = 2'd1;
            3'b010: size = 2'd2;
            3'b100: begin size = 2'd0; uns = 1'b1; end
            3'b101: begin size = 2'd1; uns = 1'b1; end
            3'b011: begin size = 2'd3; f3_legal = (XLEN == 64); end
            3'b110: begin size = 2'd2; uns = 1'b1; f3_legal = (XLEN == 64); end
            default: f3_legal = 1'b0;
        endcase
    end

    assign off_raw   = bus.addr[OFFW-1:0];
    assign size_mask = OFFW'((32'd1 << size) - 32'd1);
    // low bits that would break natural alignment are dropped; when the
    // misalignment check is enabled such accesses fault and never use this
    assign off_eff   = off_raw & ~size_mask;

`ifdef LSU_MISALIGN_CHECK_EN
    logic misaligned;
    assign misaligned   = |(off_raw & size_mask);
    assign access_fault = is_mem & (~f3_legal | misaligned);
`else
    assign access_fault = is_mem & ~f3_legal;
`endif

    assign is_uart_tx   = is_store & (bus.addr == XLEN'(UART_TX_ADDR));
    assign is_uart_stat = is_load  & (bus.addr == XLEN'(UART_STAT_ADDR));

    always_comb begin
        lane_base = NB'(1);
        wrep      = bus.wdata;
        case (size)
            2'd0: begin
                lane_base = NB'(1);
                wrep      = {NB{bus.wdata[7:0]}};
            end
            2'd1: begin
                lane_base = NB'(3);
                wrep      = {(NB/2){bus.wdata[15:0]}};
            end
            2'd2: begin
                lane_base = NB'(15);
                wrep      = {(XLEN/32){bus.wdata[31:0]}};
            end
            default: begin
                lane_base = NB'(8'hFF);
                wrep      = bus.wdata;
            end
        endcase
    end

    assign lane_mask = lane_base << off_eff;

    // ------------------------------------------------------------------------
    // UART transmit FIFO
    // ------------------------------------------------------------------------
    logic [7:0]  fifo_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, push, pop;

    assign full  = (count == (PW+1)'(TX_DEPTH));
    assign empty = (count == '0);
    assign pop   = ~empty & bus.uart_tx_ready;

    assign bus.uart_tx_valid = ~empty;
    assign bus.uart_tx_out   = empty ? 8'h00 : fifo_mem[rd_ptr];

    // ------------------------------------------------------------------------
    // Captured request and response registers
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] rsp_data_q, dmem_addr_q, dmem_wdata_q;
    logic [NB-1:0]   dmem_we_q;
    logic [4:0]      rd_q;
    logic            fault_q, load_q, uns_q;
    logic [1:0]      size_q;
    logic [OFFW-1:0] off_q;
    logic [LATW-1:0] lat_cnt;
    logic            accept, ld_capture;
    logic [XLEN-1:0] shifted, ld_data, stat_word;

    assign stat_word = XLEN'({count, full});
    assign shifted   = bus.dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_data = shifted;
        case (size_q)
            2'd0:    ld_data = uns_q ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            2'd1:    ld_data = uns_q ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            2'd2:    ld_data = uns_q ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            default: ld_data = shifted;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        ld_capture = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (!is_mem || access_fault || is_uart_stat) state_nxt = RESP;
                    else if (is_uart_tx)                         state_nxt = UART;
                    else                                         state_nxt = ACCESS;
                end
            end
            ACCESS: state_nxt = load_q ? WAIT : RESP;
            WAIT: begin
                if (lat_cnt == '0) begin
                    ld_capture = 1'b1;
                    state_nxt  = RESP;
                end
            end
            UART: begin
                // a full FIFO still accepts the byte when a pop frees a slot
                if (!full || pop) begin
                    push      = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_q   <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_we_q    <= '0;
            rd_q         <= '0;
            fault_q      <= 1'b0;
            load_q       <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= '0;
            off_q        <= '0;
            lat_cnt      <= '0;
        end else begin
            if (accept) begin
                rd_q         <= bus.rd_in;
                fault_q      <= access_fault;
                rsp_data_q   <= (is_uart_stat && !access_fault) ? stat_word : bus.addr;
                load_q       <= is_load;
                uns_q        <= uns;
                size_q       <= size;
                off_q        <= off_eff;
                dmem_addr_q  <= {bus.addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                dmem_we_q    <= is_store ? lane_mask : '0;
                dmem_wdata_q <= wrep;
            end
            if (ld_capture) rsp_data_q <= ld_data;

            if (state == ACCESS)                 lat_cnt <= LATW'(MEM_LATENCY - 1);
            else if (state == WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset: empty FIFO masks the head byte
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= dmem_wdata_q[7:0];
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.req_ready  = (state == IDLE);
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rd_out     = rd_q;
    assign bus.fault      = fault_q;
    assign bus.dmem_en    = (state == ACCESS);
    assign bus.dmem_we    = (state == ACCESS) ? dmem_we_q : '0;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;

endmodule
`default_nettype wire

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameter XLEN, default 32, datapath width; the block SHALL support only 32 and 64.
REQ-002 Parameter MEM_LATENCY, default 1, cycles from the dmem_en cycle to the cycle in which dmem_rdata is valid; the block SHALL support values 1 to 8.
REQ-003 Parameter UART_TX_ADDR, default 32'h1000_0000, MMIO transmit-data address.
REQ-004 Parameter UART_STAT_ADDR, default 32'h1000_0004, MMIO status address.
REQ-005 Parameter TX_DEPTH, default 4, UART FIFO entries; the value SHALL be a power of two, 2 to 16.
REQ-006 Ports, each as name direction width meaning:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- req_valid in 1 / req_ready out 1: request handshake.
- addr in XLEN: execute result, i.e. address or passthrough value.
- wdata in XLEN: store data.
- funct3 in 3: access size and sign.
- mem_read in 1 / mem_write in 1: operation select.
- rd_in in 5: destination register.
- rsp_valid out 1 / rsp_ready in 1: response handshake.
- rsp_data out XLEN: result.
- rd_out out 5: destination register, forwarded.
- fault out 1: response carries an access fault.
- dmem_en out 1 / dmem_we out XLEN/8 / dmem_addr out XLEN / dmem_wdata out XLEN / dmem_rdata in XLEN: memory port.
- uart_tx_out out 8 / uart_tx_valid out 1 / uart_tx_ready in 1: UART byte stream.

Function
REQ-007 The FSM SHALL have the states IDLE, ACCESS, WAIT, UART and RESP; req_ready SHALL be 1 only in IDLE.
REQ-008 On acceptance in cycle N (req_valid and req_ready):
- Neither mem_read nor mem_write: go to RESP, with rsp_valid in N+1 and rsp_data = addr.
- Store: go to ACCESS, with dmem_en = 1 for the single cycle N+1; then RESP, with rsp_valid in N+2 and rsp_data = addr.
- Load: go to ACCESS, with dmem_en = 1 in N+1; then WAIT for MEM_LATENCY cycles; dmem_rdata is registered at the end of cycle N+1+MEM_LATENCY; rsp_valid is asserted in N+2+MEM_LATENCY.
REQ-009 mem_read and mem_write both set SHALL be treated as a store.
REQ-010 funct3 SHALL be decoded as 000 B, 001 H, 010 W, 100 BU, 101 HU; 011 D and 110 WU SHALL be legal only when XLEN = 64, and any other code SHALL be a fault.
REQ-011 dmem_addr SHALL be addr with its log2(XLEN/8) LSBs cleared.
REQ-012 dmem_we SHALL carry ones in the lanes selected by size and the address LSBs, and SHALL be all zero for a load.
REQ-013 dmem_wdata SHALL be wdata replicated into every lane.
REQ-014 Load data SHALL be the selected lane, sign- or zero-extended to XLEN.
REQ-015 A store to UART_TX_ADDR (any size) SHALL go to UART without a dmem access; wdata[7:0] SHALL be pushed when the FIFO is not full, then the FSM SHALL move to RESP.
REQ-016 While the FIFO is full the FSM SHALL remain in UART (stall).
REQ-017 A load from UART_STAT_ADDR SHALL return {zero-extended FIFO count, bit0 = full} and SHALL go to RESP in N+1 with no dmem access.
REQ-018 uart_tx_valid SHALL equal FIFO not empty; uart_tx_out SHALL be the FIFO head; the FIFO SHALL pop when uart_tx_valid and uart_tx_ready are both 1.
REQ-019 A FIFO push and pop in the same cycle SHALL leave the count unchanged, and this SHALL also hold when the FIFO is full.
REQ-020 Pointers SHALL wrap modulo TX_DEPTH.
REQ-021 In RESP, rsp_valid, rsp_data, rd_out and fault SHALL be held stable until rsp_ready; in the cycle with rsp_ready the FSM SHALL return to IDLE, so a new request is accepted in the next cycle.
REQ-022 A faulting access SHALL skip memory and UART, go directly to RESP in N+1, and respond with fault = 1 and rsp_data = addr.

Reset
REQ-023 When rst is high at a clk edge the FSM SHALL go to IDLE, with rsp_valid = 0, fault = 0, dmem_en = 0, dmem_we = 0, uart_tx_valid = 0 and every data output 0.
REQ-024 Reset SHALL empty the FIFO and clear the latency counter.
REQ-025 Reset asserted mid-operation SHALL abandon the in-flight access with no response and no later dmem or UART side effect.

Configuration
REQ-026 With LSU_MISALIGN_CHECK_EN defined, an access not naturally aligned to its size SHALL be a fault (REQ-022).
REQ-027 Without LSU_MISALIGN_CHECK_EN, the offending address LSBs SHALL be forced to zero, natural alignment SHALL be assumed, and fault SHALL come only from illegal funct3.

Verification
REQ-028 The bench SHALL cover these scenarios:
- MEM_LATENCY = 3; LW at addr 0x40, dmem_rdata = 0xDEADBEEF -> dmem_en only in N+1; rsp_valid in N+5; rsp_data 0xDEADBEEF.
- LB at 0x43 with word 0x80FF_FF00 -> rsp_data 0xFFFFFF80; LBU -> 0x00000080.
- SH 0x1234 at 0x42 -> dmem_we 4'b1100, dmem_wdata 0x12341234, rsp_valid in N+2.
- TX_DEPTH = 4, uart_tx_ready = 0, five UART stores 'A' to 'E' -> fifth stalls in UART, req_ready stays 0; raising uart_tx_ready drains 'A' first, and the fifth completes.
- LW at 0x41 -> with LSU_MISALIGN_CHECK_EN: fault = 1, no dmem_en; without it: reads 0x40, fault = 0.
- rsp_ready held 0 for 3 cycles then reset pulsed -> outputs stable while held; after reset rsp_valid = 0 and the FIFO count is 0.
